instr_pipeline_ctrl: RTL and testbench
======================================

// Module: instr_pipeline_ctrl
// PURPOSE
//  Parametrised instruction pipeline controller: holds STAGES instruction
//  registers, each with a valid bit, and drives the fetch/dispatch request.
//  Supports stall, flush and a draining halt. Stage contents feed the
//  per-stage control decode ROMs. Generalises the fixed two-stage dispatch
//  path to N stages.
// PARAMETERS
//  STAGES       3      pipeline depth, 2..8
//  WIDTH        8      instruction width in bits
//  NOP          'h00   value loaded into a stage holding a bubble
//  HALT_OPCODE  'hFF   instruction value that triggers a halt
//  OCC_W        $clog2(STAGES+1)   width of OCCUPANCY
// PORTS
//  CLK          in   1               rising-edge clock
//  RST          in   1               synchronous, active-high reset
//  INSTR_IN     in   WIDTH           instruction from the memory data bus
//  INSTR_VALID  in   1               INSTR_IN is valid this cycle
//  STALL        in   1               hold all stages this cycle
//  FLUSH        in   1               discard all in-flight instructions
//  DISPATCH     out  1               fetch request; the PC increments on it
//  STAGE_INSTR  out  STAGES*WIDTH    stage i at [i*WIDTH +: WIDTH]; stage 0 is youngest
//  STAGE_VALID  out  STAGES          per-stage valid bit
//  OCCUPANCY    out  OCC_W           count of set STAGE_VALID bits (registered)
//  HALT         out  1               sticky halt indication (registered)
// BEHAVIOUR
//  - Reset: all stages = NOP; STAGE_VALID = 0; OCCUPANCY = 0; HALT = 0;
//    state = RUN. DISPATCH is forced to 0 while RST is high.
//  - Priority at each edge: RST > FLUSH > STALL > advance.
//  - States:
//    - RUN: DISPATCH = !STALL & !RST (combinational).
//    - HALTING: DISPATCH = 0.
//    - HALTED: DISPATCH = 0. Every input except RST is ignored.
//  - Advance (no stall, state not HALTED):
//    - stage[i] <= stage[i-1] for i = 1..STAGES-1.
//    - If DISPATCH & INSTR_VALID: stage[0] <= INSTR_IN and valid0 <= 1.
//    - Otherwise stage[0] <= NOP and valid0 <= 0 (bubble).
//    - The oldest stage's instruction retires.
//  - Stall: every stage, valid bit and OCCUPANCY holds. No fetch occurs.
//  - Flush:
//    - All stages <= NOP and all valid <= 0. OCCUPANCY <= 0.
//    - State HALTING -> RUN, so an in-flight halt is cancelled.
//    - Flush overrides a simultaneous STALL.
//    - Flush is ignored in HALTED.
//  - Halt entry: a valid HALT_OPCODE is loaded into stage 0 at edge k.
//    - State RUN -> HALTING at that same edge.
//    - Stages behind it fill with bubbles.
//  - Halt completion: when stage[STAGES-1] is valid and equals
//    HALT_OPCODE at an edge with STALL=0:
//    - State -> HALTED and HALT <= 1. All valid bits clear; stage data is
//      left frozen.
//    - Unstalled, HALT rises after edge k+STAGES.
//  - Instructions older than the halt complete normally.
//  - A halt with STALL asserted in the last stage waits until STALL drops.
//  - HALTED exits only on RST.
//  - OCCUPANCY is updated on the same edge as the valid bits.
//    - It equals popcount(STAGE_VALID) after every edge.
//    - Its range is 0..STAGES and it never wraps.
//  - A non-HALT instruction equal to NOP is carried as valid. Validity comes
//    only from the valid bits, never from the data value.
//  - RST asserted mid-halt or mid-stall restores the reset state on that
//    edge.
// TESTING  (STAGES=3, WIDTH=8, HALT_OPCODE=FF)
//  - Reset, then feed 01,02,03,04 with INSTR_VALID=1
//    -> after edge 3 STAGE_INSTR = {01,02,03} (oldest..youngest),
//       VALID=111, OCC=3, DISPATCH=1.
//  - Run full, then STALL=1 for 2 cycles with INSTR_IN changing
//    -> stages, OCC and DISPATCH=0 held for both cycles; after release
//       the next instruction enters stage 0.
//  - Feed 10,FF,20
//    -> DISPATCH=0 from the edge that loads FF; 20 never enters;
//       HALT=1 three edges later; VALID=000; OCC=0; later inputs ignored.
//  - FLUSH=1 together with STALL=1 while in HALTING
//    -> VALID=000, OCC=0, state RUN, DISPATCH=1 next cycle; HALT stays 0.
//  - INSTR_VALID=0 with bubbles interleaved (01,-,02)
//    -> VALID pattern 101 and OCC=2; then STAGES=8 regression with OCC
//       reaching 8 without wrap.
//  - RST pulsed while HALT=1 or mid-stall
//    -> next cycle all outputs equal reset values and DISPATCH=1 after
//       RST drops.

Source files
------------

// File: rtl/instr_pipeline_ctrl.sv
// N-stage instruction pipeline controller: per-stage instruction/valid registers,
// fetch request generation, stall, flush and a draining halt that freezes the pipe.
module instr_pipeline_ctrl #(
    parameter int                STAGES      = 3,
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  NOP         = 'h00,
    parameter logic [WIDTH-1:0]  HALT_OPCODE = 'hFF,
    parameter int                OCC_W       = $clog2(STAGES + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [WIDTH-1:0]          INSTR_IN,
    input  logic                      INSTR_VALID,
    input  logic                      STALL,
    input  logic                      FLUSH,
    output logic                      DISPATCH,
    output logic [STAGES*WIDTH-1:0]   STAGE_INSTR,
    output logic [STAGES-1:0]         STAGE_VALID,
    output logic [OCC_W-1:0]          OCCUPANCY,
    output logic                      HALT
);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALTING,
        S_HALTED
    } state_t;

    state_t                    state_q, state_d;
    logic [STAGES*WIDTH-1:0]   stage_q, stage_d;
    logic [STAGES-1:0]         valid_q, valid_d;
    logic [OCC_W-1:0]          occ_q, occ_d;
    logic                      halt_q, halt_d;
    logic                      fetch;
    logic                      halt_retiring;

    // The PC steps on DISPATCH, so it must never rise while reset is held.
    assign DISPATCH      = (state_q == S_RUN) && !STALL && !RST;
    assign fetch         = DISPATCH && INSTR_VALID;
    assign halt_retiring = valid_q[STAGES-1] &&
                           (stage_q[(STAGES-1)*WIDTH +: WIDTH] == HALT_OPCODE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the branches below can leave it unassigned and infer a latch.
        state_d = state_q;
        stage_d = stage_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        occ_d   = '0;

        if (state_q != S_HALTED) begin
            if (FLUSH) begin
                stage_d = {STAGES{NOP}};
                valid_d = '0;
                state_d = S_RUN;
            end else if (!STALL) begin
                if (halt_retiring) begin
                    // Data stays frozen for post-mortem inspection; only validity drops.
                    state_d = S_HALTED;
                    halt_d  = 1'b1;
                    valid_d = '0;
                end else begin
                    stage_d = {stage_q[(STAGES-1)*WIDTH-1:0], (fetch ? INSTR_IN : NOP)};
                    valid_d = {valid_q[STAGES-2:0], fetch};
                    if (fetch && (INSTR_IN == HALT_OPCODE)) begin
                        state_d = S_HALTING;
                    end
                end
            end
        end

        // Occupancy is derived from the next valid bits so it tracks them on the same edge.
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state_q <= S_RUN;
            // NOTE: the stage array is reset because bubbles are defined to hold
            // NOP and downstream decode reads the data even when invalid.
            stage_q <= {STAGES{NOP}};
            valid_q <= '0;
            occ_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
            halt_q  <= halt_d;
        end
    end

    assign STAGE_INSTR = stage_q;
    assign STAGE_VALID = valid_q;
    assign OCCUPANCY   = occ_q;
    assign HALT        = halt_q;

endmodule

// File: tb/tb_instr_pipeline_ctrl.sv
// Self-checking bench for instr_pipeline_ctrl: vector table with a scoreboard queue
// for the 3-stage build, plus a hand-written fill/stall/drain run on an 8-stage build.
module tb_instr_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 3-stage instance
    logic        rst, iv, stall, flush;
    logic [7:0]  instr;
    logic        disp;
    logic [23:0] st;
    logic [2:0]  vld;
    logic [1:0]  occ;
    logic        halt;

    // 8-stage instance
    logic        rst8, iv8, stall8, flush8;
    logic [7:0]  instr8;
    logic        disp8;
    logic [63:0] st8;
    logic [7:0]  vld8;
    logic [3:0]  occ8;
    logic        halt8;

    instr_pipeline_ctrl #(.STAGES(3), .WIDTH(8), .NOP(8'h00), .HALT_OPCODE(8'hFF)) u_dut (
        .CLK(clk), .RST(rst), .INSTR_IN(instr), .INSTR_VALID(iv), .STALL(stall),
        .FLUSH(flush), .DISPATCH(disp), .STAGE_INSTR(st), .STAGE_VALID(vld),
        .OCCUPANCY(occ), .HALT(halt)
    );

    instr_pipeline_ctrl #(.STAGES(8), .WIDTH(8), .NOP(8'h00), .HALT_OPCODE(8'hFF)) u_dut8 (
        .CLK(clk), .RST(rst8), .INSTR_IN(instr8), .INSTR_VALID(iv8), .STALL(stall8),
        .FLUSH(flush8), .DISPATCH(disp8), .STAGE_INSTR(st8), .STAGE_VALID(vld8),
        .OCCUPANCY(occ8), .HALT(halt8)
    );

    typedef struct {
        string       tag;
        logic        rst, iv, stall, flush;
        logic [7:0]  instr;
        logic        disp;
        logic [23:0] st;
        logic [2:0]  vld;
        logic [1:0]  occ;
        logic        halt;
    } vec_t;

    typedef struct {
        string       tag;
        logic [23:0] st;
        logic [2:0]  vld;
        logic [1:0]  occ;
        logic        halt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void add(input string tag, input logic r, input logic v,
                                input logic s, input logic f, input logic [7:0] in,
                                input logic d, input logic [23:0] e_st,
                                input logic [2:0] e_vld, input logic [1:0] e_occ,
                                input logic e_halt);
        vec_t x;
        x.tag = tag; x.rst = r; x.iv = v; x.stall = s; x.flush = f; x.instr = in;
        x.disp = d; x.st = e_st; x.vld = e_vld; x.occ = e_occ; x.halt = e_halt;
        vecs.push_back(x);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1; iv = 1'b0; stall = 1'b0; flush = 1'b0; instr = 8'h00;
        rst8 = 1'b1; iv8 = 1'b0; stall8 = 1'b0; flush8 = 1'b0; instr8 = 8'h00;

        //  tag        rst iv st fl  in     disp stage(s2,s1,s0) vld    occ  halt
        add("reset",    1, 0, 0, 0, 8'h00, 0, 24'h000000, 3'b000, 2'd0, 0);
        add("fill1",    0, 1, 0, 0, 8'h01, 1, 24'h000001, 3'b001, 2'd1, 0);
        add("fill2",    0, 1, 0, 0, 8'h02, 1, 24'h000102, 3'b011, 2'd2, 0);
        add("fill3",    0, 1, 0, 0, 8'h03, 1, 24'h010203, 3'b111, 2'd3, 0);
        add("fill4",    0, 1, 0, 0, 8'h04, 1, 24'h020304, 3'b111, 2'd3, 0);
        add("stall1",   0, 1, 1, 0, 8'h05, 0, 24'h020304, 3'b111, 2'd3, 0);
        add("stall2",   0, 1, 1, 0, 8'h06, 0, 24'h020304, 3'b111, 2'd3, 0);
        add("unstall",  0, 1, 0, 0, 8'h07, 1, 24'h030407, 3'b111, 2'd3, 0);
        add("pre_halt", 0, 1, 0, 0, 8'h10, 1, 24'h040710, 3'b111, 2'd3, 0);
        add("load_ff",  0, 1, 0, 0, 8'hFF, 1, 24'h0710FF, 3'b111, 2'd3, 0);
        add("halting1", 0, 1, 0, 0, 8'h20, 0, 24'h10FF00, 3'b110, 2'd2, 0);
        add("halting2", 0, 1, 0, 0, 8'h20, 0, 24'hFF0000, 3'b100, 2'd1, 0);
        add("halted",   0, 1, 0, 0, 8'h20, 0, 24'hFF0000, 3'b000, 2'd0, 1);
        add("hlt_flsh", 0, 1, 0, 1, 8'h30, 0, 24'hFF0000, 3'b000, 2'd0, 1);
        add("hlt_stal", 0, 1, 1, 0, 8'h31, 0, 24'hFF0000, 3'b000, 2'd0, 1);
        add("hlt_rst",  1, 1, 0, 0, 8'h32, 0, 24'h000000, 3'b000, 2'd0, 0);
        add("post_rst", 0, 0, 0, 0, 8'h00, 1, 24'h000000, 3'b000, 2'd0, 0);
        add("f_load11", 0, 1, 0, 0, 8'h11, 1, 24'h000011, 3'b001, 2'd1, 0);
        add("f_loadff", 0, 1, 0, 0, 8'hFF, 1, 24'h0011FF, 3'b011, 2'd2, 0);
        add("f_hlting", 0, 1, 0, 0, 8'h22, 0, 24'h11FF00, 3'b110, 2'd2, 0);
        add("f_flstal", 0, 1, 1, 1, 8'h22, 0, 24'h000000, 3'b000, 2'd0, 0);
        add("f_resume", 0, 1, 0, 0, 8'h23, 1, 24'h000023, 3'b001, 2'd1, 0);
        add("run_flsh", 0, 1, 0, 1, 8'h24, 1, 24'h000000, 3'b000, 2'd0, 0);
        add("bub_a",    0, 1, 0, 0, 8'h01, 1, 24'h000001, 3'b001, 2'd1, 0);
        add("bub_gap",  0, 0, 0, 0, 8'h55, 1, 24'h000100, 3'b010, 2'd1, 0);
        add("bub_b",    0, 1, 0, 0, 8'h02, 1, 24'h010002, 3'b101, 2'd2, 0);
        add("nop_vld",  0, 1, 0, 0, 8'h00, 1, 24'h000200, 3'b011, 2'd2, 0);
        add("mstall",   0, 1, 1, 0, 8'h03, 0, 24'h000200, 3'b011, 2'd2, 0);
        add("mst_rst",  1, 1, 1, 0, 8'h03, 0, 24'h000000, 3'b000, 2'd0, 0);
        add("mst_post", 0, 1, 0, 0, 8'h09, 1, 24'h000009, 3'b001, 2'd1, 0);
        add("s_loadff", 0, 1, 0, 0, 8'hFF, 1, 24'h0009FF, 3'b011, 2'd2, 0);
        add("s_drain1", 0, 0, 0, 0, 8'h00, 0, 24'h09FF00, 3'b110, 2'd2, 0);
        add("s_drain2", 0, 0, 0, 0, 8'h00, 0, 24'hFF0000, 3'b100, 2'd1, 0);
        add("s_hold1",  0, 0, 1, 0, 8'h00, 0, 24'hFF0000, 3'b100, 2'd1, 0);
        add("s_hold2",  0, 0, 1, 0, 8'h00, 0, 24'hFF0000, 3'b100, 2'd1, 0);
        add("s_halted", 0, 0, 0, 0, 8'h00, 0, 24'hFF0000, 3'b000, 2'd0, 1);
        add("s_rst",    1, 0, 0, 0, 8'h00, 0, 24'h000000, 3'b000, 2'd0, 0);
        add("inv_42",   0, 1, 0, 0, 8'h42, 1, 24'h000042, 3'b001, 2'd1, 0);
        add("inv_ff1",  0, 0, 0, 0, 8'hFF, 1, 24'h004200, 3'b010, 2'd1, 0);
        add("inv_ff2",  0, 0, 0, 0, 8'hFF, 1, 24'h420000, 3'b100, 2'd1, 0);
        add("inv_ff3",  0, 0, 0, 0, 8'hFF, 1, 24'h000000, 3'b000, 2'd0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; iv = vecs[i].iv; stall = vecs[i].stall;
            flush = vecs[i].flush; instr = vecs[i].instr;
            e.tag = vecs[i].tag; e.st = vecs[i].st; e.vld = vecs[i].vld;
            e.occ = vecs[i].occ; e.halt = vecs[i].halt;
            sb.push_back(e);
            #1 check({vecs[i].tag, ".dispatch"}, disp, vecs[i].disp);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check({vecs[i].tag, ".scoreboard_empty"}, 1, 0);
            end else begin
                e = sb.pop_front();
                check({e.tag, ".stage_instr"}, st, e.st);
                check({e.tag, ".stage_valid"}, vld, e.vld);
                check({e.tag, ".occupancy"}, occ, e.occ);
                check({e.tag, ".halt"}, halt, e.halt);
            end
        end
        check("scoreboard_drained", sb.size(), 0);

        // 8-stage regression: fill past capacity, stall while full, then drain.
        @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk);
        #1 check("s8.reset_occ", occ8, 0);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            rst8 = 1'b0; iv8 = 1'b1; stall8 = 1'b0; instr8 = 8'(n);
            #1 check($sformatf("s8.fill%0d.dispatch", n), disp8, 1);
            @(posedge clk);
            #1;
            check($sformatf("s8.fill%0d.occ", n), occ8, (n < 8) ? n : 8);
            check($sformatf("s8.fill%0d.valid", n), vld8,
                  (n < 8) ? 8'((1 << n) - 1) : 8'hFF);
            check($sformatf("s8.fill%0d.stage0", n), st8[7:0], n);
            if (n >= 8) check($sformatf("s8.fill%0d.stage7", n), st8[63:56], n - 7);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            stall8 = 1'b1; instr8 = 8'hAA;
            #1 check($sformatf("s8.stall%0d.dispatch", k), disp8, 0);
            @(posedge clk);
            #1;
            check($sformatf("s8.stall%0d.occ", k), occ8, 8);
            check($sformatf("s8.stall%0d.stage0", k), st8[7:0], 10);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            stall8 = 1'b0; iv8 = 1'b0;
            @(posedge clk);
            #1 check($sformatf("s8.drain%0d.occ", k), occ8, 8 - k);
        end
        check("s8.halt", halt8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
